aldffe_checker: RTL

- Synthesizable observer and checker for an async-load, clock-enabled D flip-flop (ALDFFE) under test.
- Sits beside the flop and samples its stimulus (D, AD, ALOAD, EN) and its output Q on every rising CLK edge.
- Maintains a reference model of the flop, flags mismatches and counts them, and captures the first failing sample.
- Pairs with the ALDFFE stimulus benches, so that flow and VCD exports carry a self-checking verdict.

---
 rtl/aldffe_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/aldffe_checker.sv
// Reference-model checker for an async-load, clock-enabled flop (ALDFFE).
// Optional ALD_CNT output (inferred async-load events) when ALDFFE_CHK_ALD_CNT_EN is defined.
module aldffe_checker #(
  parameter int WIDTH       = 2,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             CHK_EN,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] AD,
  input  logic             ALOAD,
  input  logic             EN,
  input  logic [WIDTH-1:0] Q,
  output logic             SYNCED,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [WIDTH-1:0] FIRST_Q,
  output logic [WIDTH-1:0] FIRST_EXP
`ifdef ALDFFE_CHK_ALD_CNT_EN
  ,
  output logic [CNT_W-1:0] ALD_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, FAIL} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   model_q, model_d;
  logic               synced_q, synced_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   first_q_q, first_q_d;
  logic [WIDTH-1:0]   first_exp_q, first_exp_d;
`ifdef ALDFFE_CHK_ALD_CNT_EN
  logic [CNT_W-1:0]   ald_cnt_q, ald_cnt_d;
`endif

  logic legal;
  logic err_fire;
  logic ald_evt;

  // Q may legally equal the model, or AD when an async load hit between edges.
  assign legal    = (Q == model_q) || (Q == AD);
  assign err_fire = (state_q == CHECK) && CHK_EN && !legal;
  assign ald_evt  = (state_q == CHECK) && CHK_EN && (Q == AD) && (Q != model_q);

  always_comb begin
    state_d     = state_q;
    model_d     = model_q;
    synced_d    = synced_q;
    err_d       = 1'b0;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    first_q_d   = first_q_q;
    first_exp_d = first_exp_q;
`ifdef ALDFFE_CHK_ALD_CNT_EN
    ald_cnt_d   = ald_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        model_d  = Q;
        synced_d = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        if (err_fire) begin
          err_d = 1'b1;
          cnt_d = sat_inc(cnt_q);
          if (!sticky_q) begin
            first_q_d   = Q;
            first_exp_d = model_q;
            sticky_d    = 1'b1;
          end
          if (STOP_ON_ERR) state_d = FAIL;
        end
`ifdef ALDFFE_CHK_ALD_CNT_EN
        if (ald_evt) ald_cnt_d = sat_inc(ald_cnt_q);
`endif
        // Model follows the flop's own priority: async load, then enable, then hold.
        if (ALOAD)      model_d = AD;
        else if (EN)    model_d = D;
        else if (legal) model_d = Q;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q     <= IDLE;
      model_q     <= '0;
      synced_q    <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      first_q_q   <= '0;
      first_exp_q <= '0;
`ifdef ALDFFE_CHK_ALD_CNT_EN
      ald_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      model_q     <= model_d;
      synced_q    <= synced_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      first_q_q   <= first_q_d;
      first_exp_q <= first_exp_d;
`ifdef ALDFFE_CHK_ALD_CNT_EN
      ald_cnt_q   <= ald_cnt_d;
`endif
    end
  end

  assign SYNCED     = synced_q;
  assign ERR        = err_q;
  assign ERR_STICKY = sticky_q;
  assign ERR_CNT    = cnt_q;
  assign FIRST_Q    = first_q_q;
  assign FIRST_EXP  = first_exp_q;
`ifdef ALDFFE_CHK_ALD_CNT_EN
  assign ALD_CNT    = ald_cnt_q;
`endif

  // ald_evt is only consumed when the optional counter is built.
  logic unused_ald;
  assign unused_ald = ald_evt;

endmodule
